// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential word fetch over a single-outstanding
// req/ack port, buffered with its PC in a small FIFO, drained by valid/ready.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    pcs_q  [DEPTH];
    logic           push;
    logic           pop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        pop      = 1'b0;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;

        case (state_q)
            IDLE: begin
                // Credit check: a slot is reserved before the request goes out.
                if (!redirect && (count_q < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    state_d = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            pop = (count_q != '0) && inst_ready;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_q[wr_ptr_q] <= mem_rdata;
            pcs_q[wr_ptr_q]  <= pc_q;
        end
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? data_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pcs_q[rd_ptr_q]  : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a default instance plus one whose RESET_PC
// sits near the top of the address space to exercise pc wrap.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_ready;

    logic        mem_req,  mem_req2;
    logic [31:0] mem_addr, mem_addr2;
    logic        inst_valid, inst_valid2;
    logic [31:0] inst_data, inst_data2;
    logic [31:0] inst_pc,  inst_pc2;
    logic [31:0] pc,       pc2;

    int n_cmp = 0;
    int n_err = 0;
    bit auto_ack = 1'b0;
    int pushes;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid2), .inst_data(inst_data2), .inst_pc(inst_pc2),
        .inst_ready(inst_ready), .pc(pc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge. In auto mode the
    // memory acks in the same cycle as the request with rdata = addr ^ A5A5A5A5.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            mem_ack   = mem_req;
            mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b1;

        // Reset values and free-running fetch
        auto_ack = 1'b1;
        cyc(); cyc();
        chk("rst_mem_req",    {31'b0, mem_req},    32'd0);
        chk("rst_mem_addr",   mem_addr,            32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_data",  inst_data,           32'h0);
        chk("rst_inst_pc",    inst_pc,             32'h0);
        chk("rst_pc",         pc,                  32'h0);
        chk("rst_wrap_addr",  mem_addr2,           32'hFFFF_FFF8);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("run_req%0d", k),  {31'b0, mem_req}, 32'd1);
            chk($sformatf("run_addr%0d", k), mem_addr, 32'(4 * k));
            if (k == 2) chk("wrap_addr0", mem_addr2, 32'h0000_0000);
            cyc();
            chk($sformatf("run_valid%0d", k), {31'b0, inst_valid}, 32'd1);
            chk($sformatf("run_ipc%0d", k),   inst_pc, 32'(4 * k));
            chk($sformatf("run_idata%0d", k), inst_data, 32'(4 * k) ^ 32'hA5A5_A5A5);
            chk($sformatf("run_req_gap%0d", k), {31'b0, mem_req}, 32'd0);
            if (k == 0) chk("wrap_ipc0", inst_pc2, 32'hFFFF_FFF8);
            if (k == 1) chk("wrap_ipc1", inst_pc2, 32'hFFFF_FFFC);
        end

        // Core stalled: credit limit stops fetching at DEPTH entries
        rst = 1'b1;
        cyc();
        rst = 1'b0; inst_ready = 1'b0; pushes = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (mem_req && mem_ack) pushes++;
        end
        chk("stall_pushes", 32'(pushes), 32'd4);
        chk("stall_req",    {31'b0, mem_req}, 32'd0);
        chk("stall_pc",     pc, 32'h10);
        chk("stall_head",   inst_pc, 32'h0);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        chk("pop1_head",  inst_pc, 32'h4);
        chk("pop1_data",  inst_data, 32'h4 ^ 32'hA5A5_A5A5);
        cyc();
        chk("resume_req",  {31'b0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'h10);
        cyc();
        chk("resume_pc",   pc, 32'h14);

        // Slow memory with a redirect while the request is outstanding
        auto_ack = 1'b0; mem_ack = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0; inst_ready = 1'b1;
        cyc();
        chk("slow_req", {31'b0, mem_req}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        chk("drop_req",   {31'b0, mem_req}, 32'd0);
        chk("drop_pc",    pc, 32'h100);
        chk("drop_valid", {31'b0, inst_valid}, 32'd0);
        cyc();
        chk("drop_wait_req", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0;
        chk("stale_valid", {31'b0, inst_valid}, 32'd0);
        chk("stale_pc",    pc, 32'h100);
        cyc();
        chk("refetch_req",   {31'b0, mem_req}, 32'd1);
        chk("refetch_addr",  mem_addr, 32'h100);
        chk("refetch_valid", {31'b0, inst_valid}, 32'd0);
        cyc();
        chk("refetch_wait_valid", {31'b0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        inst_ready = 1'b0;
        cyc();
        mem_ack = 1'b0;
        chk("refetch_valid2", {31'b0, inst_valid}, 32'd1);
        chk("refetch_ipc",    inst_pc, 32'h100);
        chk("refetch_idata",  inst_data, 32'h1234_5678);

        // Redirect coinciding with mem_ack and a pop
        cyc();
        chk("coinc_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        redirect = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
        cyc();
        mem_ack = 1'b0; redirect = 1'b0;
        chk("coinc_valid", {31'b0, inst_valid}, 32'd0);
        chk("coinc_data",  inst_data, 32'h0);
        chk("coinc_pc",    pc, 32'h200);
        chk("coinc_req_lo", {31'b0, mem_req}, 32'd0);
        cyc();
        chk("coinc_next_addr", mem_addr, 32'h200);
        chk("coinc_next_req",  {31'b0, mem_req}, 32'd1);

        // Reset during REQ, then a late ack that must be ignored
        rst = 1'b1;
        cyc();
        chk("rreq_req",   {31'b0, mem_req}, 32'd0);
        chk("rreq_pc",    pc, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        cyc();
        chk("rreq_req_hold", {31'b0, mem_req}, 32'd0);
        rst = 1'b0;
        cyc();
        mem_ack = 1'b0;
        chk("late_valid", {31'b0, inst_valid}, 32'd0);
        chk("late_pc",    pc, 32'h0);
        chk("late_req",   {31'b0, mem_req}, 32'd1);
        cyc();
        chk("late_valid2", {31'b0, inst_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end directly upstream of the CPU execute core.
- Generates sequential word-aligned fetch addresses and issues single-outstanding reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PC in a small FIFO and presents them to the core over a valid/ready interface.
- Exposes the current fetch PC to the test monitor; supports flush/redirect on taken branches.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned)

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- redirect  input  1  flush queue and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
- mem_req  output  1  read request to instruction memory
- mem_addr  output  32  read address, word-aligned
- mem_ack  input  1  memory has returned mem_rdata this cycle
- mem_rdata  input  32  instruction word, valid only with mem_ack
- inst_valid  output  1  head FIFO entry available
- inst_data  output  32  head instruction word
- inst_pc  output  32  address of head instruction
- inst_ready  input  1  core accepts head entry this cycle
- pc  output  32  current fetch PC register (next address to request)

Behaviour:
- Reset (rst high at clock edge): pc=RESET_PC, state=IDLE, FIFO count=0, rd/wr pointers=0.
  - Outputs during reset: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-transaction abandons any outstanding request; a later mem_ack is ignored because state is IDLE.
- States:
  - IDLE: go to REQ when count < DEPTH and no redirect this cycle.
  - REQ: mem_req=1, mem_addr=pc held stable until mem_ack.
    - mem_ack and no redirect: push {pc, mem_rdata}, pc<=pc+4, go to IDLE.
    - redirect without mem_ack: go to DROP.
    - redirect with mem_ack: discard the data, go to IDLE.
  - DROP: mem_req=0; wait for the stale mem_ack, discard it, go to IDLE.
- Request and ack rules:
  - mem_ack is only sampled in REQ/DROP; mem_ack in IDLE is ignored.
  - Ack may arrive in the same cycle mem_req first rises.
  - Maximum throughput is one fetch per 2 cycles.
- Credit rule: a request is only started when a FIFO slot is free at entry to REQ.
  - A push therefore never overflows, even if the core stalls.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Output side:
  - inst_valid = (count != 0), combinational from registers.
  - inst_data/inst_pc come from the head entry; they read 0 when empty.
  - Pop occurs on inst_valid & inst_ready.
- Redirect (any state, highest priority after rst):
  - count<=0, pointers<=0, pc<={redirect_pc[31:2],2'b00}.
  - A pop in the same cycle has no further effect.
  - inst_valid=0 from the next cycle.
  - From IDLE, the next request issues no earlier than the cycle after the redirect.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no error flag.
- Pointers wrap modulo DEPTH; count is width clog2(DEPTH)+1.

Test Plan:
- Reset then free-running memory (ack in the req cycle, rdata=addr^32'hA5A5_A5A5), inst_ready=1 -> mem_req first high in cycle 1 after rst falls. inst_pc sequence 0,4,8,C; each inst_data = pc^A5A5_A5A5; one fetch per 2 cycles.
- inst_ready=0 with an always-ack memory -> exactly 4 pushes. mem_req then stays 0 with pc=32'h10. One pop resumes fetching at 32'h10.
- Memory acks 3 cycles after req; redirect to 32'h0000_0103 one cycle after req rises -> state DROP, the stale ack is discarded with no push. Next mem_addr=32'h0000_0100, inst_valid=0 until that word returns.
- Redirect in the same cycle as mem_ack and a pop -> FIFO empty next cycle, returned word not pushed, pc=redirect target.
- RESET_PC=32'hFFFF_FFF8, two fetches -> inst_pc FFFF_FFF8, FFFF_FFFC, then mem_addr=0000_0000.
- rst asserted while in REQ, then a late mem_ack arrives -> no push, inst_valid=0, pc=RESET_PC, mem_req low during reset.
